// File: rtl/spi_request_scheduler.sv
// Shares the SPI handler between periodic thermometer polls and on-demand program reads.
// One req/ready handshake at a time; hung handshake phases are aborted and counted.
module spi_request_scheduler #(
    parameter int g_poll_period = 10000,
    parameter int g_timeout     = 4000
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_prog_req,
    output logic       o_prog_busy,
    output logic       o_prog_done,
    output logic       o_read_program,
    input  logic       i_program_ready,
    output logic       o_read_therm,
    input  logic       i_therm_ready,
    input  logic [9:0] i_spi_temperature,
    output logic [9:0] o_temperature,
    output logic       o_temp_update,
    output logic       o_temp_valid,
    output logic       o_timeout,
    output logic [7:0] o_err_count
);

    localparam int POLL_W = (g_poll_period > 2) ? $clog2(g_poll_period) : 1;
    localparam int TO_W   = (g_timeout > 2) ? $clog2(g_timeout) : 1;
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(g_poll_period - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(g_timeout - 1);

    typedef enum logic [2:0] {
        IDLE,
        T_REQ,
        T_REL,
        P_REQ,
        P_REL
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [POLL_W-1:0] poll_cnt;
    logic              poll_pend;
    logic              prog_pend;
    logic [TO_W-1:0]   phase_cnt;
    logic              phase_expired;
    logic              phase_enter;
    logic              read_therm_nxt;
    logic              read_program_nxt;
    logic              temp_update_nxt;
    logic              prog_done_nxt;
    logic              timeout_nxt;
    logic              latch_temp;

    assign phase_expired = (phase_cnt == TO_LAST);
    assign phase_enter   = (state_nxt != state) && (state_nxt != IDLE);
    assign o_prog_busy   = prog_pend || (state == P_REQ) || (state == P_REL);

    // Next-state and next-output decode; a ready seen in the expiry cycle still wins.
    always_comb begin
        state_nxt        = state;
        read_therm_nxt   = 1'b0;
        read_program_nxt = 1'b0;
        temp_update_nxt  = 1'b0;
        prog_done_nxt    = 1'b0;
        timeout_nxt      = 1'b0;
        latch_temp       = 1'b0;
        case (state)
            IDLE: begin
                if (!i_therm_ready && !i_program_ready) begin
                    if (poll_pend) begin
                        state_nxt      = T_REQ;
                        read_therm_nxt = 1'b1;
                    end else if (prog_pend) begin
                        state_nxt        = P_REQ;
                        read_program_nxt = 1'b1;
                    end
                end
            end
            T_REQ: begin
                if (i_therm_ready) begin
                    state_nxt       = T_REL;
                    latch_temp      = 1'b1;
                    temp_update_nxt = 1'b1;
                end else if (phase_expired) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end else begin
                    read_therm_nxt = 1'b1;
                end
            end
            T_REL: begin
                if (!i_therm_ready) begin
                    state_nxt = IDLE;
                end else if (phase_expired) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end
            end
            P_REQ: begin
                if (i_program_ready) begin
                    state_nxt = P_REL;
                end else if (phase_expired) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end else begin
                    read_program_nxt = 1'b1;
                end
            end
            P_REL: begin
                if (!i_program_ready) begin
                    state_nxt     = IDLE;
                    prog_done_nxt = 1'b1;
                end else if (phase_expired) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state          <= IDLE;
            o_read_therm   <= 1'b0;
            o_read_program <= 1'b0;
            o_temp_update  <= 1'b0;
            o_prog_done    <= 1'b0;
            o_timeout      <= 1'b0;
            o_temperature  <= '0;
            o_temp_valid   <= 1'b0;
            o_err_count    <= '0;
        end else begin
            state          <= state_nxt;
            o_read_therm   <= read_therm_nxt;
            o_read_program <= read_program_nxt;
            o_temp_update  <= temp_update_nxt;
            o_prog_done    <= prog_done_nxt;
            o_timeout      <= timeout_nxt;
            if (latch_temp) begin
                o_temperature <= i_spi_temperature;
                o_temp_valid  <= 1'b1;
            end
            if (timeout_nxt && (o_err_count != 8'hFF)) begin
                o_err_count <= o_err_count + 8'd1;
            end
        end
    end

    // A fresh terminal count re-arms the poll even when it lands on the grant edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            poll_cnt  <= '0;
            poll_pend <= 1'b0;
        end else begin
            if (poll_cnt == POLL_LAST) begin
                poll_cnt  <= '0;
                poll_pend <= 1'b1;
            end else begin
                poll_cnt <= poll_cnt + POLL_W'(1);
                if ((state == IDLE) && (state_nxt == T_REQ)) begin
                    poll_pend <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            prog_pend <= 1'b0;
        end else if ((state == IDLE) && (state_nxt == P_REQ)) begin
            prog_pend <= 1'b0;
        end else if (i_prog_req && (state != P_REQ) && (state != P_REL)) begin
            prog_pend <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            phase_cnt <= '0;
        end else if (phase_enter) begin
            phase_cnt <= '0;
        end else if (state != IDLE) begin
            phase_cnt <= phase_cnt + TO_W'(1);
        end
    end

endmodule

// File: tb/tb_spi_request_scheduler.sv
// Randomized bench for spi_request_scheduler: a scripted SPI handler responder plus a
// timestamp-based reference model of the scheduling rules, and a saturation run.
module tb_spi_request_scheduler;

    localparam int P  = 100;
    localparam int T  = 50;
    localparam int PS = 60;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_prog_req = 1'b0;
    logic       i_program_ready = 1'b0;
    logic       i_therm_ready = 1'b0;
    logic [9:0] i_spi_temperature = '0;
    logic       o_prog_busy, o_prog_done, o_read_program, o_read_therm;
    logic [9:0] o_temperature;
    logic       o_temp_update, o_temp_valid, o_timeout;
    logic [7:0] o_err_count;

    logic       sat_reset_n = 1'b0;
    logic       sat_zero = 1'b0;
    logic [9:0] sat_temp_in = 10'h155;
    logic       sat_busy, sat_done, sat_rdprog, sat_rdtherm, sat_upd, sat_valid, sat_to;
    logic [9:0] sat_temp;
    logic [7:0] sat_err;

    always #5 i_clk = ~i_clk;

    spi_request_scheduler #(.g_poll_period(P), .g_timeout(T)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_prog_req(i_prog_req),
        .o_prog_busy(o_prog_busy), .o_prog_done(o_prog_done),
        .o_read_program(o_read_program), .i_program_ready(i_program_ready),
        .o_read_therm(o_read_therm), .i_therm_ready(i_therm_ready),
        .i_spi_temperature(i_spi_temperature), .o_temperature(o_temperature),
        .o_temp_update(o_temp_update), .o_temp_valid(o_temp_valid),
        .o_timeout(o_timeout), .o_err_count(o_err_count)
    );

    spi_request_scheduler #(.g_poll_period(PS), .g_timeout(T)) dut_sat (
        .i_clk(i_clk), .i_reset_n(sat_reset_n), .i_prog_req(sat_zero),
        .o_prog_busy(sat_busy), .o_prog_done(sat_done),
        .o_read_program(sat_rdprog), .i_program_ready(sat_zero),
        .o_read_therm(sat_rdtherm), .i_therm_ready(sat_zero),
        .i_spi_temperature(sat_temp_in), .o_temperature(sat_temp),
        .o_temp_update(sat_upd), .o_temp_valid(sat_valid),
        .o_timeout(sat_to), .o_err_count(sat_err)
    );

    int checks = 0;
    int passed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: transaction phases tracked by the edge on which they began.
    typedef enum int {M_IDLE, M_TREQ, M_TREL, M_PREQ, M_PREL} mphase_t;
    mphase_t    m_ph;
    int         m_cyc, m_start, m_err;
    bit         m_poll, m_prog, m_valid, m_upd, m_done, m_to;
    logic [9:0] m_temp;

    task automatic modelReset();
        m_ph = M_IDLE; m_cyc = 0; m_start = 0; m_err = 0;
        m_poll = 0; m_prog = 0; m_valid = 0; m_upd = 0; m_done = 0; m_to = 0;
        m_temp = '0;
    endtask

    task automatic modelAbort();
        m_to = 1;
        if (m_err < 255) m_err++;
        m_ph = M_IDLE;
    endtask

    task automatic modelStep(input bit pulse, input bit tr, input bit pr, input logic [9:0] data);
        bit was_prog, got_t, got_p;
        int age;
        m_cyc++;
        m_upd = 0; m_done = 0; m_to = 0; got_t = 0; got_p = 0;
        was_prog = (m_ph == M_PREQ) || (m_ph == M_PREL);
        age = m_cyc - m_start;
        case (m_ph)
            M_IDLE: if (!tr && !pr) begin
                if (m_poll) begin m_ph = M_TREQ; m_start = m_cyc; got_t = 1; end
                else if (m_prog) begin m_ph = M_PREQ; m_start = m_cyc; got_p = 1; end
            end
            M_TREQ: if (tr) begin
                m_temp = data; m_valid = 1; m_upd = 1; m_ph = M_TREL; m_start = m_cyc;
            end else if (age >= T) modelAbort();
            M_TREL: if (!tr) m_ph = M_IDLE; else if (age >= T) modelAbort();
            M_PREQ: if (pr) begin m_ph = M_PREL; m_start = m_cyc; end
                    else if (age >= T) modelAbort();
            M_PREL: if (!pr) begin m_done = 1; m_ph = M_IDLE; end
                    else if (age >= T) modelAbort();
            default: m_ph = M_IDLE;
        endcase
        if (got_t) m_poll = 0;
        if (m_cyc % P == 0) m_poll = 1;
        if (got_p) m_prog = 0;
        else if (pulse && !was_prog) m_prog = 1;
    endtask

    task automatic compareAll();
        checkOutput("read_therm", 32'(o_read_therm), 32'(m_ph == M_TREQ));
        checkOutput("read_program", 32'(o_read_program), 32'(m_ph == M_PREQ));
        checkOutput("prog_busy", 32'(o_prog_busy),
                    32'(m_prog || m_ph == M_PREQ || m_ph == M_PREL));
        checkOutput("prog_done", 32'(o_prog_done), 32'(m_done));
        checkOutput("temp_update", 32'(o_temp_update), 32'(m_upd));
        checkOutput("temperature", 32'(o_temperature), 32'(m_temp));
        checkOutput("temp_valid", 32'(o_temp_valid), 32'(m_valid));
        checkOutput("timeout", 32'(o_timeout), 32'(m_to));
        checkOutput("err_count", 32'(o_err_count), 32'(m_err));
        checkOutput("req_exclusive", 32'(o_read_therm & o_read_program), 32'd0);
    endtask

    // Scripted SPI handler: channel 0 = thermometer, 1 = program memory.
    bit         armed[2], hold[2];
    int         wait_c[2], dly[2], rel[2], rel_c[2], ntrans[2];
    logic [9:0] t_data;
    bit         rand_en = 0, directed_en = 0;
    int         prog_rises = 0;
    bit         prev_prog = 0;

    function automatic int pickDelay();
        if ($urandom_range(0, 9) < 8) return int'($urandom_range(0, 30));
        return int'($urandom_range(46, 54));
    endfunction

    task automatic pickParams(input int ch);
        int idx;
        idx = ntrans[ch]++;
        if (ch == 0 && idx == 0) begin dly[0] = 20; rel[0] = 3; t_data = 10'h0B4; end
        else if (ch == 0 && idx == 1) begin dly[0] = 100000; rel[0] = 0; end
        else if (ch == 1 && idx == 0) begin dly[1] = 5; rel[1] = 3; end
        else begin
            dly[ch] = pickDelay();
            rel[ch] = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 5)) : pickDelay();
            if (ch == 0) t_data = 10'($urandom_range(0, 1023));
        end
    endtask

    task automatic responderReset();
        for (int ch = 0; ch < 2; ch++) begin armed[ch] = 0; hold[ch] = 0; end
    endtask

    task automatic applyStimulus();
        bit req;
        int nxt;
        if (!i_reset_n) begin
            i_therm_ready = 0; i_program_ready = 0; i_prog_req = 0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                req = (ch == 0) ? o_read_therm : o_read_program;
                if (!hold[ch]) begin
                    if (req) begin
                        if (!armed[ch]) begin armed[ch] = 1; wait_c[ch] = 0; pickParams(ch); end
                        if (wait_c[ch] >= dly[ch]) begin hold[ch] = 1; rel_c[ch] = 0; end
                        else wait_c[ch]++;
                    end else armed[ch] = 0;
                end else begin
                    armed[ch] = 0;
                    if (!req) begin
                        if (rel_c[ch] >= rel[ch]) hold[ch] = 0;
                        else rel_c[ch]++;
                    end
                end
            end
            i_therm_ready = hold[0];
            i_program_ready = hold[1];
            i_spi_temperature = hold[0] ? t_data : 10'($urandom_range(0, 1023));
            nxt = m_cyc + 1;
            i_prog_req = (directed_en && (nxt == 100 || nxt == 110 || nxt == 115 || nxt == 118))
                         || (rand_en && $urandom_range(0, 29) == 0);
        end
    endtask

    task automatic tick();
        applyStimulus();
        @(posedge i_clk);
        #1;
        if (!i_reset_n) begin modelReset(); responderReset(); end
        else modelStep(i_prog_req, i_therm_ready, i_program_ready, i_spi_temperature);
        compareAll();
        if (o_read_program && !prev_prog) prog_rises++;
        prev_prog = o_read_program;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        int n, e;
        modelReset();
        responderReset();
        for (int i = 0; i < 3; i++) tick();
        i_reset_n = 1;
        directed_en = 1;
        seen = 0;
        while (m_cyc < 300) begin
            tick();
            if (o_read_therm && !seen) begin
                seen = 1;
                checkOutput("first_poll_edge", 32'(m_cyc), 32'(P + 1));
            end
        end
        checkOutput("first_poll_seen", 32'(seen), 32'd1);
        checkOutput("single_prog_read", 32'(prog_rises), 32'd1);
        checkOutput("err_after_hang", 32'(o_err_count), 32'd1);
        checkOutput("temp_after_hang", 32'(o_temperature), 32'h0B4);
        directed_en = 0;
        rand_en = 1;
        while (m_cyc < 3000) tick();
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            seen = o_read_therm;
        end
        checkOutput("reached_treq", 32'(seen), 32'd1);
        i_reset_n = 0;
        tick();
        checkOutput("reset_drops_therm", 32'(o_read_therm), 32'd0);
        i_reset_n = 1;
        rand_en = 0;
        seen = 0;
        for (int i = 0; i < P + 20; i++) begin
            tick();
            if (o_read_therm) begin
                seen = 1;
                checkOutput("post_reset_first_req", 32'(m_cyc), 32'(P + 1));
                break;
            end
        end
        checkOutput("post_reset_req_seen", 32'(seen), 32'd1);
        rand_en = 1;
        while (m_cyc < 3000) tick();
        rand_en = 0;
        i_prog_req = 0;

        // Saturation run on the second instance: ready never comes back.
        @(posedge i_clk);
        #1;
        sat_reset_n = 1;
        n = 0;
        e = 0;
        while (n < 260 && e < 17000) begin
            @(posedge i_clk);
            #1;
            e++;
            if (sat_to) begin
                n++;
                checkOutput("sat_timeout_edge", 32'(e), 32'(111 + PS * (n - 1)));
                checkOutput("sat_err_count", 32'(sat_err), 32'((n > 255) ? 255 : n));
            end
        end
        checkOutput("sat_timeouts", 32'(n), 32'd260);
        checkOutput("sat_final", 32'(sat_err), 32'hFF);
        checkOutput("sat_temp_valid", 32'(sat_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
